upregs_resp: RTL and testbench

CPU-bus responder (slave end) for the internal CPU bus driven by the top-level CPU decoder. It sits inside a functional block on one clock domain and consumes `upa`/`updi`/`upen`/read strobe/write strobe. It returns `updo`/`uprdy`/`upint`, and it holds the block's common control, scratch, sticky-interrupt, mask, event-counter and live-status registers. Outputs must be zero whenever the block is not answering, because the decoder ORs data across clock domains.

---
 rtl/upregs_resp_pkg.sv | 30 +++
 rtl/upregs_istat.sv | 50 +++++
 rtl/upregs_resp.sv | 169 ++++++++++++++++
 tb/tb_upregs_resp.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upregs_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upregs_resp_pkg
// Description : Shared constants for the upregs_resp CPU-bus responder:
//               register indices, responder FSM states and EVCNT width.
// Revision    : 1.0 - initial release
// ============================================================================
package upregs_resp_pkg;

  // Register indices decoded from upa[3:0]
  localparam logic [3:0] REG_VERSION = 4'd0;
  localparam logic [3:0] REG_CTRL    = 4'd1;
  localparam logic [3:0] REG_SCRATCH = 4'd2;
  localparam logic [3:0] REG_ISTAT   = 4'd3;
  localparam logic [3:0] REG_IMASK   = 4'd4;
  localparam logic [3:0] REG_EVCNT   = 4'd5;
  localparam logic [3:0] REG_STAT    = 4'd6;

  // Width of the saturating event counter
  localparam int EVCNT_W = 16;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

endpackage : upregs_resp_pkg
`default_nettype wire

// File: rtl/upregs_istat.sv
`default_nettype none
// ============================================================================
// Module      : upregs_istat
// Description : Sticky interrupt status bank. Events set bits, CPU writes of
//               1 clear them, and a set wins over a clear in the same cycle.
//               Produces the registered masked interrupt level.
// Revision    : 1.0 - initial release
// ============================================================================
module upregs_istat #(
  parameter int NEVT = 8
) (
  input  logic            clk155,
  input  logic            rst_,
  input  logic [NEVT-1:0] evt_in,
  input  logic            w1c_en,
  input  logic [NEVT-1:0] w1c_data,
  input  logic [NEVT-1:0] mask,
  output logic [NEVT-1:0] istat,
  output logic            irq
);

  logic [NEVT-1:0] istat_q;
  logic [NEVT-1:0] istat_d;
  logic            irq_q;

  // Next sticky state: clear the written ones, then re-apply any new events
  always_comb begin
    istat_d = istat_q;
    if (w1c_en) begin
      istat_d = istat_q & ~w1c_data;
    end
    istat_d = istat_d | evt_in;
  end

  // Sticky bits and the interrupt level, which lags status/mask by one cycle
  always_ff @(posedge clk155 or negedge rst_) begin
    if (!rst_) begin
      istat_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      istat_q <= istat_d;
      irq_q   <= |(istat_q & mask);
    end
  end

  assign istat = istat_q;
  assign irq   = irq_q;

endmodule : upregs_istat
`default_nettype wire

// File: rtl/upregs_resp.sv
`default_nettype none
// ============================================================================
// Module      : upregs_resp
// Description : CPU-bus responder holding the block's common registers
//               (version, control, scratch, sticky interrupts, mask, event
//               counter, live status). Read/write data and acknowledge are
//               forced to zero whenever this block is not answering.
// Revision    : 1.0 - initial release
// ============================================================================
module upregs_resp
  import upregs_resp_pkg::*;
#(
  parameter int          RDLAT   = 2,
  parameter logic [31:0] VERSION = 32'h0001_0000,
  parameter int          NEVT    = 8
) (
  input  logic            clk155,
  input  logic            rst_,
  input  logic [23:0]     upa,
  input  logic            upen,
  input  logic            uprs,
  input  logic            upws,
  input  logic [31:0]     updi,
  input  logic [NEVT-1:0] evt_in,
  input  logic [31:0]     stat_in,
  output logic [31:0]     updo,
  output logic            uprdy,
  output logic            upint,
  output logic [31:0]     ctrl
);

  localparam logic [2:0] RDLAT_C = 3'(RDLAT);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          hold_q;
  logic [31:0]          ctrl_q;
  logic [31:0]          scratch_q;
  logic [NEVT-1:0]      mask_q;
  logic [EVCNT_W-1:0]   evcnt_q, evcnt_d;

  logic [3:0]           idx;
  logic                 acc_any, acc_wr, acc_rd;
  logic                 ack_w, rd_last_w;
  logic [31:0]          rd_mux;
  logic [NEVT-1:0]      istat;
  logic                 irq;
  logic                 unused_upa;

  assign idx        = upa[3:0];
  assign unused_upa = ^upa[23:4];

  // Only an idle responder takes a strobe; a write beats a simultaneous read
  assign acc_any = upen & (uprs | upws) & (state_q == ST_IDLE);
  assign acc_wr  = acc_any & upws;
  assign acc_rd  = acc_any & ~upws;

  // FSM state and read-latency counter
  always_ff @(posedge clk155 or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; the read counter starts at 1 so the ack lands RDLAT after the strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_w     = 1'b0;
    rd_last_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_wr) begin
          state_d = ST_WR;
        end else if (acc_rd) begin
          state_d = ST_RD;
          cnt_d   = 3'd1;
        end
      end
      ST_WR: begin
        ack_w   = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD: begin
        if (cnt_q == RDLAT_C) begin
          ack_w     = 1'b1;
          rd_last_w = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux; unused upper bits and unmapped indices read 0
  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_VERSION: rd_mux = VERSION;
      REG_CTRL:    rd_mux = ctrl_q;
      REG_SCRATCH: rd_mux = scratch_q;
      REG_ISTAT:   rd_mux[NEVT-1:0] = istat;
      REG_IMASK:   rd_mux[NEVT-1:0] = mask_q;
      REG_EVCNT:   rd_mux[EVCNT_W-1:0] = evcnt_q;
      REG_STAT:    rd_mux = stat_in;
      default:     rd_mux = '0;
    endcase
  end

  // Event counter: saturating increment, cleared by a read capture (a same-cycle event leaves 1)
  always_comb begin
    evcnt_d = evcnt_q;
    if (acc_rd && (idx == REG_EVCNT)) begin
      evcnt_d = {{(EVCNT_W-1){1'b0}}, evt_in[0]};
    end else if (evt_in[0] && (evcnt_q != {EVCNT_W{1'b1}})) begin
      evcnt_d = evcnt_q + {{(EVCNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Writable registers, read-hold capture and event counter
  always_ff @(posedge clk155 or negedge rst_) begin
    if (!rst_) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      mask_q    <= '0;
      hold_q    <= '0;
      evcnt_q   <= '0;
    end else begin
      if (acc_wr) begin
        case (idx)
          REG_CTRL:    ctrl_q    <= updi;
          REG_SCRATCH: scratch_q <= updi;
          REG_IMASK:   mask_q    <= updi[NEVT-1:0];
          default:     ;
        endcase
      end
      if (acc_rd) begin
        hold_q <= rd_mux;
      end
      evcnt_q <= evcnt_d;
    end
  end

  upregs_istat #(
    .NEVT (NEVT)
  ) u_istat (
    .clk155   (clk155),
    .rst_     (rst_),
    .evt_in   (evt_in),
    .w1c_en   (acc_wr && (idx == REG_ISTAT)),
    .w1c_data (updi[NEVT-1:0]),
    .mask     (mask_q),
    .istat    (istat),
    .irq      (irq)
  );

  assign uprdy = ack_w;
  assign updo  = rd_last_w ? hold_q : 32'h0;
  assign upint = irq;
  assign ctrl  = ctrl_q;

endmodule : upregs_resp
`default_nettype wire

// File: tb/tb_upregs_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_upregs_resp
// Description : Self-checking bench for upregs_resp: directed vector table,
//               hand-written interrupt/counter/boundary sequences and
//               randomized accesses against a behavioural register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upregs_resp;

  localparam int          RDLAT   = 2;
  localparam logic [31:0] VERSION = 32'h0001_0000;
  localparam int          NEVT    = 8;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic [23:0]     upa = '0;
  logic            upen = 1'b0;
  logic            uprs = 1'b0;
  logic            upws = 1'b0;
  logic [31:0]     updi = '0;
  logic [NEVT-1:0] evt_in = '0;
  logic [31:0]     stat_in = '0;
  logic [31:0]     updo;
  logic            uprdy;
  logic            upint;
  logic [31:0]     ctrl;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural register model
  logic [31:0]     m_ctrl, m_scratch;
  logic [NEVT-1:0] m_istat, m_mask;
  int              m_evcnt;

  upregs_resp #(.RDLAT(RDLAT), .VERSION(VERSION), .NEVT(NEVT)) dut (
    .clk155 (clk), .rst_ (rst_), .upa (upa), .upen (upen), .uprs (uprs),
    .upws (upws), .updi (updi), .evt_in (evt_in), .stat_in (stat_in),
    .updo (updo), .uprdy (uprdy), .upint (upint), .ctrl (ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_scratch = '0; m_istat = '0; m_mask = '0; m_evcnt = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a, input logic [31:0] st);
    case (a)
      4'd0: return VERSION;
      4'd1: return m_ctrl;
      4'd2: return m_scratch;
      4'd3: return {24'h0, m_istat};
      4'd4: return {24'h0, m_mask};
      4'd5: return 32'(m_evcnt);
      4'd6: return st;
      default: return 32'h0;
    endcase
  endfunction

  // Register effects of one clock edge
  task automatic m_edge(input bit wr, input bit rd, input logic [3:0] a,
                        input logic [31:0] d, input logic [NEVT-1:0] ev);
    if (wr) begin
      case (a)
        4'd1: m_ctrl = d;
        4'd2: m_scratch = d;
        4'd3: m_istat = m_istat & ~d[NEVT-1:0];
        4'd4: m_mask = d[NEVT-1:0];
        default: ;
      endcase
    end
    m_istat = m_istat | ev;
    if (rd && a == 4'd5) m_evcnt = ev[0] ? 1 : 0;
    else if (ev[0]) m_evcnt = (m_evcnt >= 65535) ? 65535 : m_evcnt + 1;
  endtask

  task automatic pulse_evt(input logic [NEVT-1:0] ev);
    @(negedge clk);
    evt_in = ev;
    @(posedge clk);
    m_edge(1'b0, 1'b0, 4'd0, 32'h0, ev);
    #1 evt_in = '0;
  endtask

  // One bus access with full protocol checking; returns the acknowledged data
  task automatic access(input bit wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [NEVT-1:0] ev, input bit rs_too, output logic [31:0] got);
    logic [31:0] exp;
    int          lat;
    bit          acked, zero_ok;
    @(negedge clk);
    upa    = {20'($urandom), a};
    upen   = 1'b1;
    uprs   = !wr || rs_too;
    upws   = wr;
    updi   = d;
    evt_in = ev;
    exp    = m_read(a, stat_in);
    @(posedge clk);
    m_edge(wr, !wr, a, d, ev);
    #1;
    uprs = 1'b0; upws = 1'b0; evt_in = '0;
    stat_in = ~stat_in;
    chk(ctrl === m_ctrl, "ctrl_vis", ctrl, m_ctrl);
    acked = 1'b0; zero_ok = 1'b1; lat = 0; got = '0;
    for (int k = 1; k <= 8 && !acked; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (uprdy === 1'b1) begin
        acked = 1'b1; lat = k; got = updo;
      end else if (updo !== 32'h0) begin
        zero_ok = 1'b0;
      end
    end
    upen = 1'b0;
    chk(lat == (wr ? 1 : RDLAT), "ack_lat", 32'(lat), 32'(wr ? 1 : RDLAT));
    if (wr) chk(got === 32'h0, "wr_updo", got, 32'h0);
    else    chk(got === exp, "rd_data", got, exp);
    chk(zero_ok, "updo_idle", 32'(zero_ok), 32'd1);
    @(posedge clk);
    #1;
    chk(uprdy === 1'b0 && updo === 32'h0, "ack_pulse", {31'h0, uprdy}, 32'h0);
    chk(upint === |(m_istat & m_mask), "upint", {31'h0, upint}, {31'h0, |(m_istat & m_mask)});
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[19];
  logic [31:0] got;
  int          acks;

  initial begin
    vecs[0]  = '{0, 4'd0, 32'h0,         32'h0001_0000};
    vecs[1]  = '{0, 4'd1, 32'h0,         32'h0};
    vecs[2]  = '{0, 4'd2, 32'h0,         32'h0};
    vecs[3]  = '{0, 4'd3, 32'h0,         32'h0};
    vecs[4]  = '{0, 4'd5, 32'h0,         32'h0};
    vecs[5]  = '{1, 4'd1, 32'hA5A5_0F0F, 32'h0};
    vecs[6]  = '{0, 4'd1, 32'h0,         32'hA5A5_0F0F};
    vecs[7]  = '{1, 4'd2, 32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{0, 4'd2, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1, 4'd0, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{0, 4'd0, 32'h0,         32'h0001_0000};
    vecs[11] = '{0, 4'd9, 32'h0,         32'h0};
    vecs[12] = '{1, 4'd9, 32'h1234_5678, 32'h0};
    vecs[13] = '{0, 4'd9, 32'h0,         32'h0};
    vecs[14] = '{1, 4'd4, 32'hFFFF_FF00, 32'h0};
    vecs[15] = '{0, 4'd4, 32'h0,         32'h0};
    vecs[16] = '{1, 4'd4, 32'h0000_0104, 32'h0};
    vecs[17] = '{0, 4'd4, 32'h0,         32'h0000_0004};
    vecs[18] = '{0, 4'd6, 32'h0,         32'hCAFE_1234};

    // Reset state
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk(uprdy === 1'b0, "rst_uprdy", {31'h0, uprdy}, 32'h0);
    chk(updo === 32'h0, "rst_updo", updo, 32'h0);
    chk(upint === 1'b0, "rst_upint", {31'h0, upint}, 32'h0);
    chk(ctrl === 32'h0, "rst_ctrl", ctrl, 32'h0);
    @(negedge clk) rst_ = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      stat_in = 32'hCAFE_1234;
      access(vecs[i].wr, vecs[i].a, vecs[i].d, '0, 1'b0, got);
      if (!vecs[i].wr) chk(got === vecs[i].exp, $sformatf("vec%0d", i), got, vecs[i].exp);
    end
    access(1, 4'd4, 32'h0, '0, 1'b0, got);

    // Simultaneous read and write strobes: the write wins
    access(1, 4'd2, 32'h0BAD_F00D, '0, 1'b1, got);
    access(0, 4'd2, 32'h0, '0, 1'b0, got);
    chk(got === 32'h0BAD_F00D, "write_wins", got, 32'h0BAD_F00D);

    // Interrupts
    pulse_evt(8'h04);
    access(0, 4'd3, 32'h0, '0, 1'b0, got);
    chk(got === 32'h4, "istat_set", got, 32'h4);
    chk(upint === 1'b0, "upint_masked", {31'h0, upint}, 32'h0);
    access(1, 4'd4, 32'h4, '0, 1'b0, got);
    chk(upint === 1'b1, "upint_unmasked", {31'h0, upint}, 32'h1);
    access(1, 4'd3, 32'h4, 8'h04, 1'b0, got);
    access(0, 4'd3, 32'h0, '0, 1'b0, got);
    chk(got === 32'h4, "istat_set_prio", got, 32'h4);
    access(1, 4'd3, 32'h4, '0, 1'b0, got);
    chk(upint === 1'b0, "upint_cleared", {31'h0, upint}, 32'h0);
    access(0, 4'd3, 32'h0, '0, 1'b0, got);
    chk(got === 32'h0, "istat_cleared", got, 32'h0);

    // Event counter
    access(0, 4'd5, 32'h0, '0, 1'b0, got);
    repeat (5) pulse_evt(8'h01);
    access(0, 4'd5, 32'h0, '0, 1'b0, got);
    chk(got === 32'd5, "evcnt5", got, 32'd5);
    access(0, 4'd5, 32'h0, '0, 1'b0, got);
    chk(got === 32'd0, "evcnt_cor", got, 32'd0);
    access(0, 4'd5, 32'h0, 8'h01, 1'b0, got);
    access(0, 4'd5, 32'h0, '0, 1'b0, got);
    chk(got === 32'd1, "evcnt_coincide", got, 32'd1);
    @(negedge clk) evt_in = 8'h01;
    repeat (70000) @(posedge clk);
    #1 evt_in = '0;
    m_evcnt = (m_evcnt + 70000 > 65535) ? 65535 : m_evcnt + 70000;
    m_istat = m_istat | 8'h01;
    access(0, 4'd5, 32'h0, '0, 1'b0, got);
    chk(got === 32'h0000_FFFF, "evcnt_sat", got, 32'h0000_FFFF);

    // upen low: no acknowledge, no write effect
    @(negedge clk);
    upa = 24'h1; upen = 1'b0; uprs = 1'b1; upws = 1'b0;
    @(negedge clk);
    uprs = 1'b0; upws = 1'b1; updi = 32'h1357_9BDF;
    @(negedge clk) upws = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (uprdy === 1'b1) acks++;
    end
    chk(acks == 0, "noen_ack", 32'(acks), 32'd0);
    chk(ctrl === m_ctrl, "noen_ctrl", ctrl, m_ctrl);

    // Second read strobe during RD is ignored
    @(negedge clk);
    upa = 24'h0; upen = 1'b1; uprs = 1'b1;
    @(posedge clk);
    #1 uprs = 1'b0;
    acks = (uprdy === 1'b1) ? 1 : 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) uprs = 1'b1;
      @(posedge clk);
      #1 uprs = 1'b0;
      if (uprdy === 1'b1) begin
        acks++;
        chk(updo === VERSION, "dbl_rd_data", updo, VERSION);
      end
    end
    upen = 1'b0;
    chk(acks == 1, "dbl_rd_acks", 32'(acks), 32'd1);

    // Reset during RD
    pulse_evt(8'h04);
    @(posedge clk);
    @(negedge clk);
    upa = 24'h6; upen = 1'b1; uprs = 1'b1;
    @(posedge clk);
    #1 uprs = 1'b0;
    @(negedge clk) rst_ = 1'b0;
    #1;
    chk(uprdy === 1'b0 && updo === 32'h0, "rst_rd_ack", updo, 32'h0);
    chk(upint === 1'b0, "rst_rd_upint", {31'h0, upint}, 32'h0);
    chk(ctrl === 32'h0, "rst_rd_ctrl", ctrl, 32'h0);
    acks = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (uprdy === 1'b1) acks++;
    end
    @(negedge clk) rst_ = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (uprdy === 1'b1) acks++;
    end
    upen = 1'b0;
    chk(acks == 0, "rst_rd_noack", 32'(acks), 32'd0);
    m_reset();
    access(0, 4'd1, 32'h0, '0, 1'b0, got);
    chk(got === 32'h0, "rst_rd_ctrl_rd", got, 32'h0);

    // Randomized accesses against the model
    for (int n = 0; n < 250; n++) begin
      logic [NEVT-1:0] ev;
      ev = ($urandom_range(0, 3) == 0) ? NEVT'($urandom) : '0;
      stat_in = $urandom;
      if ($urandom_range(0, 5) == 0) pulse_evt(NEVT'($urandom));
      access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, ev,
             1'($urandom_range(0, 1)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_upregs_resp
`default_nettype wire
